// File: rtl/lid_pkg.sv
// Shared types and codes for the lid motion sequencer: FSM states, lid position codes and
// stepper speed-select codes.
package lid_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRunOpen,
        StRunClose,
        StSettle,
        StFault
    } lid_fsm_e;

    localparam logic [1:0] LID_CLOSED  = 2'b00;
    localparam logic [1:0] LID_BETWEEN = 2'b01;
    localparam logic [1:0] LID_OPEN    = 2'b10;
    localparam logic [1:0] LID_FAULT   = 2'b11;

    localparam logic [1:0] MODE_FAST = 2'b00;
    localparam logic [1:0] MODE_SLOW = 2'b01;

endpackage

// File: rtl/step_edge_detect.sv
// Synchronises the stepper coil pattern and emits a one-cycle pulse whenever a new nonzero
// coil pattern appears.
module step_edge_detect (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_coil,
    output logic       o_step_pulse
);

    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] r_last_nz;
    logic       w_step;

    // An all-zero pattern is the idle interface; only a change between nonzero patterns is a step.
    assign w_step       = (r_sync2 != 4'b0000) && (r_sync2 != r_last_nz);
    assign o_step_pulse = w_step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= 4'b0000;
            r_sync2   <= 4'b0000;
            r_last_nz <= 4'b0000;
        end else begin
            r_sync1 <= i_coil;
            r_sync2 <= r_sync1;
            if (w_step) begin
                r_last_nz <= r_sync2;
            end
        end
    end

endmodule

// File: rtl/lid_motion_sequencer.sv
// Lid stepper sequencer: accepts open/close/stop requests, drives the stepper interface, tracks
// lid position from coil steps and enforces travel limits, settle time and a stall timeout.
module lid_motion_sequencer
    import lid_pkg::*;
#(
    parameter int unsigned OPEN_STEPS     = 512,
    parameter int unsigned SLOW_STEPS     = 32,
    parameter int unsigned SETTLE_CYCLES  = 1_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned POS_W          = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req_open,
    input  logic             i_req_close,
    input  logic             i_req_stop,
    input  logic [3:0]       i_coil_in,
    output logic             o_motor_dir,
    output logic             o_motor_en,
    output logic [1:0]       o_motor_mode,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_fault,
    output logic [POS_W-1:0] o_lid_pos,
    output logic [1:0]       o_lid_state
);

    localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned STALL_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [STALL_W-1:0]  STALL_LAST  = STALL_W'(TIMEOUT_CYCLES - 1);
    localparam logic [POS_W-1:0]    POS_MAX     = POS_W'(OPEN_STEPS);
    localparam logic [POS_W-1:0]    POS_SLOW    = POS_W'(SLOW_STEPS);

    lid_fsm_e            r_state, w_state_d;
    logic                r_dir, w_dir_d;
    logic                r_complete, w_complete_d;
    logic                w_done_d;
    logic [POS_W-1:0]    r_pos, w_pos_d;
    logic [SETTLE_W-1:0] r_settle;
    logic [STALL_W-1:0]  r_stall;
    logic                w_step;
    logic                w_running, w_run_d;
    logic                w_at_target;
    logic                w_stall_hit;
    logic [POS_W-1:0]    w_remaining;

    logic                r_motor_en;
    logic [1:0]          r_motor_mode;
    logic                r_busy;
    logic                r_done;
    logic                r_fault;
    logic [1:0]          r_lid_state;

    step_edge_detect u_step_edge_detect (
        .clk          (clk),
        .rst          (rst),
        .i_coil       (i_coil_in),
        .o_step_pulse (w_step)
    );

    assign w_running   = (r_state == StRunOpen) || (r_state == StRunClose);
    assign w_at_target = (r_state == StRunOpen) ? (w_pos_d == POS_MAX) : (w_pos_d == '0);
    assign w_stall_hit = !w_step && (r_stall == STALL_LAST);

    // Trailing steps after the motor is disabled still move the lid in the last direction.
    always_comb begin
        w_pos_d = r_pos;
        if (w_step) begin
            if (r_dir) begin
                if (r_pos != '0) w_pos_d = r_pos - 1'b1;
            end else if (r_pos != POS_MAX) begin
                w_pos_d = r_pos + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_dir_d      = r_dir;
        w_complete_d = r_complete;
        w_done_d     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_req_open && !i_req_close) begin
                    if (r_pos != POS_MAX) begin
                        w_state_d = StRunOpen;
                        w_dir_d   = 1'b0;
                    end else begin
                        w_done_d = 1'b1;
                    end
                end else if (i_req_close && !i_req_open) begin
                    if (r_pos != '0) begin
                        w_state_d = StRunClose;
                        w_dir_d   = 1'b1;
                    end else begin
                        w_done_d = 1'b1;
                    end
                end
            end
            StRunOpen, StRunClose: begin
                if (i_req_stop) begin
                    w_state_d    = StSettle;
                    w_complete_d = 1'b0;
                end else if (w_at_target) begin
                    w_state_d    = StSettle;
                    w_complete_d = 1'b1;
                end else if (w_stall_hit) begin
                    w_state_d = StFault;
                end
            end
            StSettle: begin
                if (r_settle == SETTLE_LAST) begin
                    w_state_d = StIdle;
                    w_done_d  = r_complete;
                end
            end
            StFault: begin
                w_state_d = StFault;
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign w_run_d     = (w_state_d == StRunOpen) || (w_state_d == StRunClose);
    assign w_remaining = w_dir_d ? w_pos_d : (POS_MAX - w_pos_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_dir        <= 1'b0;
            r_complete   <= 1'b0;
            r_pos        <= '0;
            r_settle     <= '0;
            r_stall      <= '0;
            r_motor_en   <= 1'b0;
            r_motor_mode <= MODE_FAST;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fault      <= 1'b0;
            r_lid_state  <= LID_CLOSED;
        end else begin
            r_state    <= w_state_d;
            r_dir      <= w_dir_d;
            r_complete <= w_complete_d;
            r_pos      <= w_pos_d;

            if (r_state != StSettle) begin
                r_settle <= '0;
            end else if (r_settle != SETTLE_LAST) begin
                r_settle <= r_settle + 1'b1;
            end

            if (!w_running || w_step) begin
                r_stall <= '0;
            end else if (r_stall != STALL_LAST) begin
                r_stall <= r_stall + 1'b1;
            end

            r_motor_en   <= w_run_d;
            r_motor_mode <= (w_run_d && (w_remaining <= POS_SLOW)) ? MODE_SLOW : MODE_FAST;
            r_busy       <= (w_state_d != StIdle);
            r_done       <= w_done_d;
            r_fault      <= (w_state_d == StFault);
            if (w_state_d == StFault)     r_lid_state <= LID_FAULT;
            else if (w_pos_d == '0)       r_lid_state <= LID_CLOSED;
            else if (w_pos_d == POS_MAX)  r_lid_state <= LID_OPEN;
            else                          r_lid_state <= LID_BETWEEN;
        end
    end

    assign o_motor_dir  = r_dir;
    assign o_motor_en   = r_motor_en;
    assign o_motor_mode = r_motor_mode;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_fault      = r_fault;
    assign o_lid_pos    = r_pos;
    assign o_lid_state  = r_lid_state;

endmodule
